// File: rtl/mealy_toggle_bank.sv
// Bank of independent 1-bit Mealy channels gated by a shared prescaler tick.
// Optional input synchronizer enabled by defining MEALY_SYNC_IN_EN.
module mealy_toggle_bank #(
    parameter int unsigned CH  = 4,
    parameter int unsigned DIV = 2
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic [CH-1:0] A,
    input  logic          mode,
    output logic [CH-1:0] L,
    output logic          tick
);

    localparam int unsigned CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    typedef enum logic {
        S0 = 1'b0,
        S1 = 1'b1
    } ch_state_e;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CH-1:0] a_s;
    ch_state_e     st_q [CH];
    ch_state_e     st_d [CH];

    // Prescaler: wraps after DIV-1; tick is decoded straight from the count.
    assign tick = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef MEALY_SYNC_IN_EN
    logic [CH-1:0] sync1_q, sync1_d;
    logic [CH-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = A;
        sync2_d = sync1_q;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign a_s = sync2_q;
`else
    assign a_s = A;
`endif

    // S1 clears on tick with a request in toggle mode, or on any tick in pulse mode.
    always_comb begin
        for (int unsigned i = 0; i < CH; i++) begin
            st_d[i] = st_q[i];
            case (st_q[i])
                S0: if (tick && a_s[i])           st_d[i] = S1;
                S1: if (tick && (mode || a_s[i])) st_d[i] = S0;
                default: st_d[i] = S0;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < CH; i++) begin
                st_q[i] <= S0;
            end
        end else begin
            for (int unsigned i = 0; i < CH; i++) begin
                st_q[i] <= st_d[i];
            end
        end
    end

    always_comb begin
        L = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            L[i] = (st_q[i] == S1);
        end
    end

endmodule

// File: tb/tb_mealy_toggle_bank.sv
// Directed bench for mealy_toggle_bank (DIV=2 and DIV=5 instances) with a cycle model.
module tb_mealy_toggle_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] a;
    logic       mode;
    logic [3:0] l2, l5;
    logic       t2, t5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mealy_toggle_bank #(.CH(4), .DIV(2)) u_dut2 (
        .CLK(clk), .reset(reset), .A(a), .mode(mode), .L(l2), .tick(t2)
    );

    mealy_toggle_bank #(.CH(4), .DIV(5)) u_dut5 (
        .CLK(clk), .reset(reset), .A(a), .mode(mode), .L(l5), .tick(t5)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: edges since reset define the tick; each channel follows the plain rule table.
    int       m_edges = 0;
    bit [3:0] m_l2 = '0;
    bit [3:0] m_l5 = '0;

    function automatic bit m_tick(input int div);
        return (m_edges % div) == (div - 1);
    endfunction

    function automatic bit rule(input bit s, input bit req, input bit tk, input bit md);
        if (!tk) return s;
        if (md)  return s ? 1'b0 : req;
        return s ^ req;
    endfunction

    always @(posedge clk or posedge reset) begin : model
        bit tk2, tk5;
        if (reset) begin
            m_edges = 0;
            m_l2    = '0;
            m_l5    = '0;
        end else begin
            tk2 = m_tick(2);
            tk5 = m_tick(5);
            for (int i = 0; i < 4; i++) begin
                m_l2[i] = rule(m_l2[i], a[i], tk2, mode);
                m_l5[i] = rule(m_l5[i], a[i], tk5, mode);
            end
            m_edges = m_edges + 1;
        end
    end

    always @(negedge clk) begin
        chk("model_L_div2", {28'd0, l2}, {28'd0, m_l2});
        chk("model_L_div5", {28'd0, l5}, {28'd0, m_l5});
        chk("model_tick_div2", {31'd0, t2}, {31'd0, m_tick(2)});
        chk("model_tick_div5", {31'd0, t5}, {31'd0, m_tick(5)});
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        a     = 4'b0000;
        mode  = 1'b0;
        step(2);
        chk("reset_L", {28'd0, l2}, 32'h0);
        chk("reset_tick2", {31'd0, t2}, 32'h0);
        chk("reset_tick5", {31'd0, t5}, 32'h0);

        // Toggle mode, channel 0 held high.
        reset = 1'b0;
        a     = 4'b0001;
        step(1); chk("tog_e1", {28'd0, l2}, 32'h0);
        step(1); chk("tog_e2", {28'd0, l2}, 32'h1);
        chk("model_pin_e2", {28'd0, m_l2}, 32'h1);
        step(2); chk("tog_e4", {28'd0, l2}, 32'h0);
        step(2); chk("tog_e6", {28'd0, l2}, 32'h1);
        a = 4'b0000;

        // Async reset mid-cycle, then a pulse-mode request on channel 1.
        #1 reset = 1'b1;
        #1 chk("async_rst_L", {28'd0, l2}, 32'h0);
        chk("async_rst_tick", {31'd0, t2}, 32'h0);
        step(1);
        reset = 1'b0;
        mode  = 1'b1;
        step(1);
        chk("pulse_tick_before", {31'd0, t2}, 32'h1);
        a = 4'b0010;
        step(1); a = 4'b0000;
        chk("pulse_e2", {28'd0, l2}, 32'h2);
        step(1); chk("pulse_e3", {28'd0, l2}, 32'h2);
        step(1); chk("pulse_e4", {28'd0, l2}, 32'h0);

        // Requests with tick low are ignored.
        chk("notick_tick", {31'd0, t2}, 32'h0);
        a = 4'b1111;
        step(1); a = 4'b0000;
        chk("notick_e5", {28'd0, l2}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            step(1); chk("notick_hold", {28'd0, l2}, 32'h0);
        end

        // Reach 1010 in toggle mode, reset, then all-ones toggle at edge 2.
        mode = 1'b0;
        chk("pre1010_tick", {31'd0, t2}, 32'h1);
        a = 4'b1010;
        step(1); a = 4'b0000;
        chk("reach_1010", {28'd0, l2}, 32'ha);
        #1 reset = 1'b1;
        #1 chk("rst1010_L", {28'd0, l2}, 32'h0);
        chk("rst1010_tick", {31'd0, t2}, 32'h0);
        step(2);
        reset = 1'b0;
        a     = 4'b1111;
        step(1); chk("rel_e1", {28'd0, l2}, 32'h0);
        step(1); chk("rel_e2", {28'd0, l2}, 32'hf);
        chk("div5_e2", {28'd0, l5}, 32'h0);
        step(2); chk("div5_e4", {28'd0, l5}, 32'h0);
        chk("div5_tick_e4", {31'd0, t5}, 32'h1);
        step(1); chk("div5_e5", {28'd0, l5}, 32'hf);
        step(5); chk("div5_e10", {28'd0, l5}, 32'h0);
        chk("div2_e10", {28'd0, l2}, 32'hf);
        chk("model_pin_div5", {28'd0, m_l5}, 32'h0);

        // Directed pattern sweep checked by the model every cycle.
        for (int k = 0; k < 120; k++) begin
            a    = 4'((k * 7 + k / 3) ^ (k >> 2));
            mode = ((k / 17) % 2) == 1;
            if (k == 60) begin
                #1 reset = 1'b1;
            end
            if (k == 62) begin
                reset = 1'b0;
            end
            step(1);
        end
        a = 4'b0000;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
